// File: rtl/gray_sync_pkg.sv
// Shared helpers for Gray-coded pointer crossings: code conversion, bit counting
// and the registered event bundle produced by the evaluate stage.
package gray_sync_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] word_t;

  typedef struct packed {
    logic changed;
    logic wrap;
    logic err_step;
    logic range_err;
  } evt_t;

  // Zero-extended inputs convert correctly: leading zeros contribute nothing to the prefix xor.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int unsigned popcount(input word_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Bare multi-flop synchroniser for a Gray-coded word; no logic between stages.
module gray_sync_chain #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
    end else begin
      s_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) s_q[i] <= s_q[i-1];
    end
  end

  assign q_o = s_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Destination-side consumer of a Gray count: resynchronise, convert to binary,
// report per-cycle advance and flag illegal steps or out-of-range codes.
module gray_ptr_sync
  import gray_sync_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic             changed,
  output logic [WIDTH-1:0] delta,
  output logic             wrap,
  output logic             err_step,
  output logic             range_err,
  output logic             err_sticky
);

  localparam int                 DELTA_W = WIDTH + 1;
  localparam logic [DELTA_W-1:0] MOD_D   = DELTA_W'(MODULUS);
  localparam logic [WIDTH-1:0]   LAST_V  = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0]   g, gray_prev_q, b, pb;
  logic [WIDTH-1:0]   bin_q, bin_d, delta_q, delta_d;
  logic [DELTA_W-1:0] diff;
  logic               chg, wrap_c, one_bit, legal;
  logic               sticky_q, sticky_d;
  evt_t               evt_q, evt_d;

  gray_sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_chain (
    .clk  (clk),
    .reset(reset),
    .d_i  (gray_in),
    .q_o  (g)
  );

  always_comb begin
    b       = WIDTH'(gray2bin(word_t'(g)));
    pb      = WIDTH'(gray2bin(word_t'(gray_prev_q)));
    chg     = (g != gray_prev_q);
    one_bit = (popcount(word_t'(g ^ gray_prev_q)) == 32'd1);
    // Wrap may flip several bits when MODULUS is not a power of two.
    wrap_c  = (pb == LAST_V) && (b == '0);
    legal   = one_bit || wrap_c;
    diff    = {1'b0, b} - {1'b0, pb};
    delta_d = '0;
    if (chg) delta_d = WIDTH'(diff[DELTA_W-1] ? diff + MOD_D : diff);
    bin_d           = b;
    evt_d           = '0;
    evt_d.changed   = chg;
    evt_d.wrap      = chg && wrap_c;
    evt_d.err_step  = chg && !legal;
    evt_d.range_err = ({1'b0, b} >= MOD_D);
    // A fresh error pulse outranks a simultaneous clear.
    sticky_d = evt_q.err_step || evt_q.range_err || (sticky_q && !clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray_prev_q <= '0;
      bin_q       <= '0;
      delta_q     <= '0;
      evt_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      gray_prev_q <= g;
      bin_q       <= bin_d;
      delta_q     <= delta_d;
      evt_q       <= evt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign gray_sync  = g;
  assign bin_out    = bin_q;
  assign delta      = delta_q;
  assign changed    = evt_q.changed;
  assign wrap       = evt_q.wrap;
  assign err_step   = evt_q.err_step;
  assign range_err  = evt_q.range_err;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench: a MODULUS=16 instance driven from a vector table, plus a
// MODULUS=10 instance and reset scenarios exercised by hand sequences.
module tb_gray_ptr_sync;

  logic       clk, reset;
  logic [3:0] gray_in, gray_sync, bin_out, delta;
  logic       clr_err, changed, wrap, err_step, range_err, err_sticky;
  logic [3:0] gray2, gsync2, bin2, delta2;
  logic       clr2, changed2, wrap2, err2, range2, sticky2;

  int n_chk  = 0;
  int n_fail = 0;

  gray_ptr_sync #(.WIDTH(4), .MODULUS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .clr_err(clr_err),
    .gray_sync(gray_sync), .bin_out(bin_out), .changed(changed), .delta(delta),
    .wrap(wrap), .err_step(err_step), .range_err(range_err), .err_sticky(err_sticky)
  );

  gray_ptr_sync #(.WIDTH(4), .MODULUS(10), .SYNC_STAGES(2)) dut10 (
    .clk(clk), .reset(reset), .gray_in(gray2), .clr_err(clr2),
    .gray_sync(gsync2), .bin_out(bin2), .changed(changed2), .delta(delta2),
    .wrap(wrap2), .err_step(err2), .range_err(range2), .err_sticky(sticky2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       clr;
    logic [3:0] bin;
    logic [3:0] dlt;
    logic       wrap;
    logic       err;
    logic       stk;
    logic       stk_af;
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] g, input logic clr, input logic [3:0] bin,
                              input logic [3:0] dlt, input logic wr, input logic er,
                              input logic stk, input logic stk_af);
    vec_t v;
    v.g = g; v.clr = clr; v.bin = bin; v.dlt = dlt;
    v.wrap = wr; v.err = er; v.stk = stk; v.stk_af = stk_af;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    gray_in = v.g;
    clr_err = v.clr;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("r%0d gray_sync", idx), 32'(gray_sync), 32'(v.g));
    chk($sformatf("r%0d changed_early", idx), 32'(changed), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("r%0d bin_out", idx), 32'(bin_out), 32'(v.bin));
    chk($sformatf("r%0d changed", idx), 32'(changed), 32'd1);
    chk($sformatf("r%0d delta", idx), 32'(delta), 32'(v.dlt));
    chk($sformatf("r%0d wrap", idx), 32'(wrap), 32'(v.wrap));
    chk($sformatf("r%0d err_step", idx), 32'(err_step), 32'(v.err));
    chk($sformatf("r%0d range_err", idx), 32'(range_err), 32'd0);
    chk($sformatf("r%0d sticky", idx), 32'(err_sticky), 32'(v.stk));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("r%0d quiet", idx), {27'd0, changed, wrap, err_step, range_err, 1'b0}, 32'd0);
    chk($sformatf("r%0d delta_idle", idx), 32'(delta), 32'd0);
    chk($sformatf("r%0d bin_hold", idx), 32'(bin_out), 32'(v.bin));
    chk($sformatf("r%0d sticky_after", idx), 32'(err_sticky), 32'(v.stk_af));
  endtask

  initial begin
    // Vector table: gray, clr, bin, delta, wrap, err_step, sticky@pulse, sticky after
    tbl[0] = mk(4'b0001, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(4'b0011, 1'b0, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(4'b0010, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(4'b0110, 1'b0, 4'd4,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(4'b0111, 1'b0, 4'd5,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(4'b0101, 1'b0, 4'd6,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(4'b0100, 1'b0, 4'd7,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(4'b1100, 1'b0, 4'd8,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(4'b1101, 1'b0, 4'd9,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(4'b1111, 1'b0, 4'd10, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(4'b1110, 1'b0, 4'd11, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(4'b1010, 1'b0, 4'd12, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(4'b1011, 1'b0, 4'd13, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(4'b1001, 1'b0, 4'd14, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(4'b1000, 1'b0, 4'd15, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(4'b0000, 1'b0, 4'd0,  4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(4'b0001, 1'b0, 4'd1,  4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[17] = mk(4'b0100, 1'b0, 4'd7,  4'd6, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[18] = mk(4'b0101, 1'b1, 4'd6,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(4'b0111, 1'b0, 4'd5,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[20] = mk(4'b0110, 1'b0, 4'd4,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[21] = mk(4'b0010, 1'b0, 4'd3,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[22] = mk(4'b0011, 1'b0, 4'd2,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[23] = mk(4'b0001, 1'b0, 4'd1,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0);

    reset = 1'b1; gray_in = '0; clr_err = 1'b0; gray2 = '0; clr2 = 1'b0;
    #3;
    chk("reset_async_outs", {15'd0, gray_sync, bin_out, delta, changed, wrap, err_step,
        range_err, err_sticky}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("idle_c%0d", c), {15'd0, gray_sync, bin_out, delta, changed, wrap,
          err_step, range_err, err_sticky}, 32'd0);
    end

    for (int i = 0; i < 24; i++) apply(tbl[i], i);

    // MODULUS=10 instance: count up to 9, wrap to 0
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      gray2 = 4'(i ^ (i >> 1));
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    chk("m10 bin9", 32'(bin2), 32'd9);
    gray2 = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("m10 wrap", 32'(wrap2), 32'd1);
    chk("m10 wrap_err", 32'(err2), 32'd0);
    chk("m10 wrap_delta", 32'(delta2), 32'd1);
    chk("m10 wrap_bin", 32'(bin2), 32'd0);
    // Out-of-range code (bin 10) from 0: four bits flip too
    gray2 = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("m10 range_err", 32'(range2), 32'd1);
    chk("m10 range_step", 32'(err2), 32'd1);
    chk("m10 range_bin", 32'(bin2), 32'd10);
    @(posedge clk);
    @(negedge clk);
    chk("m10 sticky_set", 32'(sticky2), 32'd1);
    chk("m10 range_hold", 32'(range2), 32'd1);
    clr2 = 1'b1;
    @(posedge clk);
    #1 clr2 = 1'b0;
    @(negedge clk);
    chk("m10 set_wins", 32'(sticky2), 32'd1);
    gray2 = 4'b0000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("m10 range_clear", 32'(range2), 32'd0);
    clr2 = 1'b1;
    @(posedge clk);
    #1 clr2 = 1'b0;
    @(negedge clk);
    chk("m10 sticky_clr", 32'(sticky2), 32'd0);

    // Mid-run asynchronous reset with bin_out = 9
    @(negedge clk);
    gray_in = 4'b1101;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_reset bin", 32'(bin_out), 32'd9);
    #2 reset = 1'b1;
    #1;
    chk("midreset outs", {15'd0, gray_sync, bin_out, delta, changed, wrap, err_step,
        range_err, err_sticky}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_reset err_step", 32'(err_step), 32'd1);
    chk("post_reset delta", 32'(delta), 32'd9);
    chk("post_reset bin", 32'(bin_out), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_ptr_sync.md
Name: gray_ptr_sync

Overview:
- Destination-domain consumer of a free-running Gray-coded count produced by a Gray counter in another clock domain.
- Resynchronises the Gray word through a flop chain and converts it to binary.
- Reports per-cycle advance (delta, wrap) and flags illegal multi-bit transitions or out-of-range codes.
- Used as the pointer-crossing stage in async FIFOs and cross-domain event counters.

Parameters:
- WIDTH, 4, bit width of Gray input and binary output.
- MODULUS, 16, count modulus of the upstream counter (2 ≤ MODULUS ≤ 2^WIDTH); wrap MODULUS-1 -> 0 is legal.
- SYNC_STAGES, 2, synchroniser depth (≥ 2).

Ports:
- clk  input  1  destination-domain clock.
- reset  input  1  asynchronous, active-high; clock clk.
- gray_in  input  WIDTH  Gray count from source domain (asynchronous to clk).
- clr_err  input  1  synchronous clear of err_sticky.
- gray_sync  output  WIDTH  synchronised Gray value (last sync flop).
- bin_out  output  WIDTH  binary equivalent of gray_sync, registered.
- changed  output  1  one-cycle pulse: new value differs from previous.
- delta  output  WIDTH  (bin_new - bin_prev) mod MODULUS, valid when changed=1, else 0.
- wrap  output  1  one-cycle pulse on legal MODULUS-1 -> 0 transition.
- err_step  output  1  one-cycle pulse: illegal transition.
- range_err  output  1  one-cycle pulse: converted value ≥ MODULUS.
- err_sticky  output  1  set by err_step or range_err; held until clr_err or reset.

Behaviour:
- Reset (async, active-high): every sync flop, gray_sync, prev register, bin_out, delta and all flags go to 0. Initial prev value is 0.
- Sync chain: gray_in -> s[0] -> … -> s[SYNC_STAGES-1] = gray_sync. No logic between flops.
- Evaluate stage, one register stage after gray_sync:
  - g = gray_sync, p = gray_prev.
  - gray_prev <= g every cycle.
  - b = gray2bin(g), pb = gray2bin(p).
- Latency: gray_in stable before edge E appears on gray_sync after edge E+SYNC_STAGES-1. bin_out and all flags update at edge E+SYNC_STAGES. Total SYNC_STAGES+1 edges.
- bin_out <= b every cycle.
- changed <= (g != p).
- Legal transition (changed=1 and either condition holds):
  - popcount(g ^ p) == 1, or
  - pb == MODULUS-1 and b == 0. This is the wrap case. It is legal even when several bits change, which covers a non-power-of-2 MODULUS.
- wrap <= changed and pb == MODULUS-1 and b == 0.
- err_step <= changed and not legal.
- delta:
  - changed=1: (b - pb) mod MODULUS, computed in WIDTH+1 bits; add MODULUS if negative.
  - changed=0: 0.
  - Still reported when err_step=1.
- range_err <= (b ≥ MODULUS). Never fires when MODULUS = 2^WIDTH.
- err_sticky:
  - Set on the cycle after err_step or range_err rises, i.e. when either registered pulse is 1.
  - Cleared by clr_err.
  - clr_err and a new error in the same cycle: set wins.
- Backward step (b = pb-1) is an illegal transition only when popcount ≠ 1. A single-bit backward step is legal, with delta = MODULUS-1.
- Reset mid-operation: all state returns to 0. The first post-reset transition is compared against prev=0 and may legitimately flag err_step if the source is not also reset.
- No handshake: the block samples continuously. Source must change gray_in by at most one legal step per destination-sampling window.

Decomposition:
- Package gray_sync_pkg:
  - function gray2bin(WIDTH) using an xor prefix from MSB.
  - function popcount.
  - localparam DELTA_W = WIDTH+1.
- Sub-module gray_sync_chain(WIDTH, SYNC_STAGES): the bare flop chain with async reset, reusable for other crossings.
- Top module holds the evaluate stage and flags.

Test Plan:
- Reset, gray_in=0 -> all outputs 0 for ≥5 cycles. Assert reset mid-run with bin_out=9 -> all outputs 0 immediately, asynchronously.
- WIDTH=4, MODULUS=16, SYNC_STAGES=2; step gray_in 0→1→3→2, one change every 4 clocks:
  - bin_out = 1, 2, 3 each 3 edges after its change.
  - changed pulses 1 cycle each, delta=1.
  - no errors.
- Count through 15 (gray 1000) → 0 (gray 0000) -> wrap=1 and delta=1 for one cycle, err_step=0.
- MODULUS=10: drive 9 (gray 1101) → 0 -> wrap=1, err_step=0. Then force gray 1111 (bin 10) -> range_err=1, err_sticky=1.
- Jump gray 0001 → 0100 (2-bit change) -> err_step=1 for 1 cycle, delta=6, err_sticky stays 1. Pulse clr_err -> err_sticky=0 next cycle.
- Backward single-bit step gray 0011 → 0001 (bin 2→1) -> err_step=0, delta=15 (MODULUS-1).
